// File: rtl/uart_prog_loader_pkg.sv
// Shared definitions for the serial program loader: receiver states and baud divisors.
package uart_prog_loader_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;

    localparam int UBRR_DEFAULT = 10415;
    localparam int UBRR_SIM     = 15;
endpackage

// File: rtl/uart_prog_loader_if.sv
// Serial line, load control and CPU fetch/status signals of the program loader.
interface uart_prog_loader_if #(parameter int ADDR_W = 5);
    logic              RX;
    logic              Load;
    logic [ADDR_W-1:0] PC;
    logic [7:0]        data_out;
    logic              FE;
    logic              Busy;
    logic              Done;

    modport master (output RX, Load, PC, input data_out, FE, Busy, Done);
    modport slave  (input RX, Load, PC, output data_out, FE, Busy, Done);
endinterface

// File: rtl/uart_prog_loader_rx_byte.sv
// 8N1 byte receiver: RX synchroniser, mid-bit sampling baud counter and frame FSM.
module uart_rx_byte
    import uart_prog_loader_pkg::*;
#(
    parameter int UBRR = UBRR_DEFAULT
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       RX,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int CNT_W = $clog2(UBRR + 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(UBRR / 2);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(UBRR);

    rx_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic             rx_s1, rx_s2, rx_prev;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            data       <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            rx_s1      <= 1'b1;
            rx_s2      <= 1'b1;
            rx_prev    <= 1'b1;
        end else begin
            rx_s1      <= RX;
            rx_s2      <= rx_s1;
            rx_prev    <= rx_s2;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: if (rx_prev && !rx_s2) begin
                    state <= START;
                    cnt   <= '0;
                end
                // a start bit that is high again at its midpoint was a glitch
                START: if (cnt == HALF) begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    state   <= rx_s2 ? IDLE : DATA;
                end else cnt <= cnt + 1'b1;
                DATA: if (cnt == FULL) begin
                    cnt  <= '0;
                    data <= {rx_s2, data[7:1]};
                    if (bit_idx == 3'd7) state <= STOP;
                    else bit_idx <= bit_idx + 3'd1;
                end else cnt <= cnt + 1'b1;
                STOP: if (cnt == FULL) begin
                    cnt        <= '0;
                    byte_valid <= rx_s2;
                    frame_err  <= !rx_s2;
                    state      <= IDLE;
                end else cnt <= cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
endmodule

// File: rtl/uart_prog_loader.sv
// Serial program loader: writes received bytes sequentially into a 2**ADDR_W x 8 program RAM
// while Load is high; the CPU reads mem[PC] combinationally.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int UBRR   = UBRR_DEFAULT,
    parameter int ADDR_W = 5
) (
    input logic                Clk,
    input logic                Rst,
    uart_prog_loader_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [7:0]        rx_data;
    logic              byte_valid, frame_err;
    logic              load_q, fe, done;
    logic [ADDR_W-1:0] wr_addr;
    logic              load_rise, done_eff, we;
    logic [ADDR_W-1:0] addr_eff;
    logic [7:0]        mem [DEPTH] = '{default: 8'h00};

    uart_rx_byte #(.UBRR(UBRR)) u_rx (
        .Clk        (Clk),
        .Rst        (Rst),
        .RX         (bus.RX),
        .data       (rx_data),
        .byte_valid (byte_valid),
        .frame_err  (frame_err),
        .busy       (bus.Busy)
    );

    // A Load rise in the same cycle as a byte restarts the image, so that byte lands at 0.
    assign load_rise = bus.Load && !load_q;
    assign addr_eff  = load_rise ? '0 : wr_addr;
    assign done_eff  = load_rise ? 1'b0 : done;
    assign we        = !Rst && byte_valid && bus.Load && !done_eff;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            load_q  <= 1'b0;
            wr_addr <= '0;
            fe      <= 1'b0;
            done    <= 1'b0;
        end else begin
            load_q  <= bus.Load;
            wr_addr <= addr_eff;
            done    <= done_eff;
            fe      <= (fe && !load_rise) || frame_err;
            if (we) begin
                wr_addr <= addr_eff + ADDR_W'(1);
                if (addr_eff == '1) done <= 1'b1;
            end
        end
    end

    // RAM contents survive Rst; only configuration initialises them.
    always_ff @(posedge Clk) begin
        if (we) mem[addr_eff] <= rx_data;
    end

    assign bus.data_out = mem[bus.PC];
    assign bus.FE       = fe;
    assign bus.Done     = done;
endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader with a 16-clock bit period.
module tb_uart_prog_loader;
    import uart_prog_loader_pkg::*;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic dp, dq;

    always #5 Clk = ~Clk;

    uart_prog_loader_if #(.ADDR_W(5)) bus ();

    uart_prog_loader #(.UBRR(UBRR_SIM), .ADDR_W(5)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [4:0] pc, input logic [7:0] exp, input string tag);
        bus.PC = pc;
        #1;
        chk(tag, bus.data_out, exp);
    endtask

    // One 8N1 frame; samples Done just before and just after the write slot of this frame.
    task automatic send_byte(input logic [7:0] b, input logic stop, input logic drop_load,
                             output logic d_pre, output logic d_post);
        bus.RX = 1'b0;
        repeat (16) @(negedge Clk);
        for (int i = 0; i < 8; i++) begin
            bus.RX = b[i];
            repeat (8) @(negedge Clk);
            if (i == 0) chk("busy_in_frame", {7'd0, bus.Busy}, 8'd1);
            if (i == 3 && drop_load) bus.Load = 1'b0;
            repeat (8) @(negedge Clk);
        end
        bus.RX = stop;
        repeat (11) @(negedge Clk);
        d_pre = bus.Done;
        @(negedge Clk);
        d_post = bus.Done;
        repeat (4) @(negedge Clk);
        bus.RX = 1'b1;
        repeat (4) @(negedge Clk);
    endtask

    initial begin
        bus.RX = 1'b1; bus.Load = 1'b0; bus.PC = 5'd7;
        // reset
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        chk("rst_fe",   {7'd0, bus.FE},   8'd0);
        chk("rst_busy", {7'd0, bus.Busy}, 8'd0);
        chk("rst_done", {7'd0, bus.Done}, 8'd0);
        rd(5'd7, 8'h00, "rst_mem7");

        // basic load
        bus.Load = 1'b1;
        @(negedge Clk);
        send_byte(8'hFE, 1'b1, 1'b0, dp, dq);
        send_byte(8'h00, 1'b1, 1'b0, dp, dq);
        send_byte(8'h00, 1'b1, 1'b0, dp, dq);
        send_byte(8'hBA, 1'b1, 1'b0, dp, dq);
        rd(5'd0, 8'hFE, "load_mem0");
        rd(5'd3, 8'hBA, "load_mem3");
        chk("load_done", {7'd0, bus.Done}, 8'd0);
        chk("load_fe",   {7'd0, bus.FE},   8'd0);

        // framing error, then good byte at the same address
        send_byte(8'h55, 1'b0, 1'b0, dp, dq);
        chk("fe_set", {7'd0, bus.FE}, 8'd1);
        rd(5'd4, 8'h00, "fe_no_write");
        send_byte(8'h20, 1'b1, 1'b0, dp, dq);
        rd(5'd4, 8'h20, "fe_next_byte");
        rd(5'd5, 8'h00, "fe_addr_next_empty");
        chk("fe_sticky", {7'd0, bus.FE}, 8'd1);
        bus.Load = 1'b0;
        repeat (2) @(negedge Clk);
        bus.Load = 1'b1;
        repeat (2) @(negedge Clk);
        chk("fe_cleared", {7'd0, bus.FE}, 8'd0);

        // glitch on RX
        bus.RX = 1'b0;
        repeat (4) @(negedge Clk);
        bus.RX = 1'b1;
        chk("glitch_busy", {7'd0, bus.Busy}, 8'd1);
        repeat (9) @(negedge Clk);
        chk("glitch_idle", {7'd0, bus.Busy}, 8'd0);
        chk("glitch_fe",   {7'd0, bus.FE},   8'd0);
        rd(5'd0, 8'hFE, "glitch_no_write");

        // full 32-byte image plus one extra
        bus.Load = 1'b0;
        repeat (2) @(negedge Clk);
        bus.Load = 1'b1;
        repeat (2) @(negedge Clk);
        for (int i = 0; i < 33; i++) begin
            send_byte(8'(i), 1'b1, 1'b0, dp, dq);
            if (i == 30) chk("done_early", {7'd0, dq}, 8'd0);
            if (i == 31) begin
                chk("done_pre",  {7'd0, dp}, 8'd0);
                chk("done_post", {7'd0, dq}, 8'd1);
            end
        end
        chk("full_done", {7'd0, bus.Done}, 8'd1);
        rd(5'd0,  8'h00, "full_mem0");
        rd(5'd1,  8'h01, "full_mem1");
        rd(5'd31, 8'h1F, "full_mem31");

        // reset mid-frame
        bus.Load = 1'b0;
        repeat (2) @(negedge Clk);
        bus.Load = 1'b1;
        repeat (2) @(negedge Clk);
        chk("reload_done_clr", {7'd0, bus.Done}, 8'd0);
        bus.RX = 1'b0;
        repeat (16) @(negedge Clk);
        bus.RX = 1'b1;
        repeat (8) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        chk("rst_mid_busy", {7'd0, bus.Busy}, 8'd0);
        repeat (20) @(negedge Clk);
        send_byte(8'hE3, 1'b1, 1'b0, dp, dq);
        rd(5'd0, 8'hE3, "rst_mid_e3");
        rd(5'd1, 8'h01, "rst_ram_kept");

        // Load dropped mid-frame
        send_byte(8'h77, 1'b1, 1'b1, dp, dq);
        rd(5'd1, 8'h01, "drop_no_write");
        bus.Load = 1'b1;
        repeat (2) @(negedge Clk);
        send_byte(8'h5A, 1'b1, 1'b0, dp, dq);
        rd(5'd0, 8'h5A, "relaunch_mem0");
        rd(5'd1, 8'h01, "relaunch_mem1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
